fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives the team's 16x8 dual-port RAM (DualPR) as a first-in first-out buffer. It accepts push/pop requests from producer and consumer logic and generates the RAM write and read ports (wr_en/Addr_wr/Data_in and rd_en/Addr_rd). It forwards read data with a valid strobe and reports occupancy, full/empty and sticky error flags. It sits directly upstream of the RAM, and the RAM's Data_out returns through this block.

---
 rtl/fifo_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller wrapped around a 16x8 dual-port RAM.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   push/din, pop, clr_err       producer/consumer requests, sticky error clear
//   ram_wr_en/addr_wr/din        RAM write port (combinational, same-edge write)
//   ram_rd_en/addr_rd, ram_dout  RAM read port; data returns one clk later
//   dout/dout_valid              popped word and its strobe
//   count/full/empty/almost_full occupancy status
//   overflow/underflow           sticky error flags
module fifo_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned AFULL_LVL = 12
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   input  logic              clr_err,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr_wr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr_rd,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ok, pop_ok;

   // Status derived from registered pointers; MSB is the wrap bit.
   always_comb begin
      empty       = (wp_q == rp_q);
      full        = (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]) &&
                    (wp_q[ADDR_W] != rp_q[ADDR_W]);
      count       = wp_q - rp_q;
      almost_full = (count >= PTR_W'(AFULL_LVL));
      push_ok     = push & ~full;
      pop_ok      = pop & ~empty;
   end

   // RAM port drive; a full FIFO never writes, so no same-address collision.
   always_comb begin
      ram_wr_en   = push_ok;
      ram_addr_wr = wp_q[ADDR_W-1:0];
      ram_din     = din;
      ram_rd_en   = pop_ok;
      ram_addr_rd = rp_q[ADDR_W-1:0];
   end

   // Next-state: pointer advance, read strobe, sticky errors (new error beats clear).
   always_comb begin
      wp_d         = wp_q;
      rp_d         = rp_q;
      dout_valid_d = pop_ok;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      if (push_ok) wp_d = wp_q + PTR_W'(1);
      if (pop_ok)  rp_d = rp_q + PTR_W'(1);
      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (push & full)  overflow_d  = 1'b1;
      if (pop  & empty) underflow_d = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp_q         <= '0;
         rp_q         <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Read data is a straight passthrough of the RAM output.
   always_comb begin
      dout       = ram_dout;
      dout_valid = dout_valid_q;
      overflow   = overflow_q;
      underflow  = underflow_q;
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a behavioural 16x8 RAM attached.
module tb_fifo_ctrl;

   logic       clk;
   logic       resetn;
   logic       push;
   logic [7:0] din;
   logic       pop;
   logic       clr_err;
   logic       ram_wr_en;
   logic [3:0] ram_addr_wr;
   logic [7:0] ram_din;
   logic       ram_rd_en;
   logic [3:0] ram_addr_rd;
   logic [7:0] ram_dout;
   logic [7:0] dout;
   logic       dout_valid;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       overflow;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [16];

   fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(12)) dut (
      .clk(clk), .resetn(resetn), .push(push), .din(din), .pop(pop),
      .clr_err(clr_err), .ram_wr_en(ram_wr_en), .ram_addr_wr(ram_addr_wr),
      .ram_din(ram_din), .ram_rd_en(ram_rd_en), .ram_addr_rd(ram_addr_rd),
      .ram_dout(ram_dout), .dout(dout), .dout_valid(dout_valid),
      .count(count), .full(full), .empty(empty), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: write on edge, registered read one clk after rd_en.
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
      if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic [7:0] d, input logic po, input logic c);
      push    = p;
      din     = d;
      pop     = po;
      clr_err = c;
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_dvalid", 32'(dout_valid), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      resetn = 1'b1;

      // Idle: no RAM activity.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_wr_en", 32'(ram_wr_en), 32'd0);
         chk("idle_rd_en", 32'(ram_rd_en), 32'd0);
         chk("idle_empty", 32'(empty), 32'd1);
      end

      // Fill 16 words 0x11..0x20.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
         chk("fill_wr_en", 32'(ram_wr_en), 32'd1);
         chk("fill_addr_wr", 32'(ram_addr_wr), 32'(i));
         tick();
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
         chk("fill_empty", 32'(empty), 32'd0);
      end
      chk("full_set", 32'(full), 32'd1);

      // Push while full is dropped.
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_wr_en", 32'(ram_wr_en), 32'd0);
      tick();
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);

      // Drain 16 words, never seeing 0xAA.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_rd_en", 32'(ram_rd_en), 32'd1);
         chk("drain_addr_rd", 32'(ram_addr_rd), 32'(i));
         tick();
         chk("drain_dvalid", 32'(dout_valid), 32'd1);
         chk("drain_dout", 32'(dout), 32'(8'h11 + i));
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      tick();
      chk("drain_dvalid_low", 32'(dout_valid), 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Pop while empty.
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_rd_en", 32'(ram_rd_en), 32'd0);
      tick();
      chk("udf_flag", 32'(underflow), 32'd1);
      chk("udf_dvalid", 32'(dout_valid), 32'd0);
      // New error in same cycle as clear: error wins.
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      chk("udf_err_wins", 32'(underflow), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("udf_cleared", 32'(underflow), 32'd0);

      // Push+pop while empty: only the push happens (wp=rp=16 -> addr 0).
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      chk("pe_wr_en", 32'(ram_wr_en), 32'd1);
      chk("pe_rd_en", 32'(ram_rd_en), 32'd0);
      tick();
      chk("pe_count", 32'(count), 32'd1);
      chk("pe_udf", 32'(underflow), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk("pe_addr_rd", 32'(ram_addr_rd), 32'd0);
      tick();
      chk("pe_dout", 32'(dout), 32'h55);
      chk("pe_udf_clr", 32'(underflow), 32'd0);

      // Fill 8 (0x30..0x37) starting at address 1.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
         tick();
      end
      chk("f8_count", 32'(count), 32'd8);

      // 40 simultaneous push/pop cycles across the pointer wrap.
      for (int k = 0; k < 40; k++) begin
         drive(1'b1, 8'(8'h38 + k), 1'b1, 1'b0);
         chk("pp_addr_wr", 32'(ram_addr_wr), 32'((25 + k) % 16));
         chk("pp_addr_rd", 32'(ram_addr_rd), 32'((17 + k) % 16));
         tick();
         chk("pp_count", 32'(count), 32'd8);
         chk("pp_dout", 32'(dout), 32'(8'h30 + k));
      end
      for (int k = 40; k < 48; k++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         tick();
         chk("pp_tail_dout", 32'(dout), 32'(8'h30 + k));
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pp_empty", 32'(empty), 32'd1);

      // Fill to full with 0x60.., then push+pop while full: only the pop.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
         tick();
      end
      chk("f16_full", 32'(full), 32'd1);
      drive(1'b1, 8'hBB, 1'b1, 1'b0);
      chk("pf_wr_en", 32'(ram_wr_en), 32'd0);
      chk("pf_rd_en", 32'(ram_rd_en), 32'd1);
      tick();
      chk("pf_count", 32'(count), 32'd15);
      chk("pf_ovf", 32'(overflow), 32'd1);
      chk("pf_dout", 32'(dout), 32'h60);
      // One more pop so dout_valid is high, then asynchronous reset mid-cycle.
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("pre_rst_dvalid", 32'(dout_valid), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_dvalid", 32'(dout_valid), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      tick();
      resetn = 1'b1;

      // Restart from address 0.
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      chk("rs_addr_wr", 32'(ram_addr_wr), 32'd0);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rs_addr_rd", 32'(ram_addr_rd), 32'd0);
      tick();
      chk("rs_dout", 32'(dout), 32'h77);
      chk("rs_dvalid", 32'(dout_valid), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
